// File: rtl/fsqrt_iter.sv
// Iterative floating-point square root: restoring digit recurrence producing
// BPC root bits per clock, round-to-nearest-even, flush-to-zero subnormals.
module fsqrt_iter #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BPC    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   y,
  output logic                    flag_invalid
);

  localparam int N     = (FRAC_W + 2 + BPC - 1) / BPC;
  localparam int K     = N * BPC;
  localparam int EXTRA = K - FRAC_W - 2;
  localparam int SHIFT = 2 * K - 2 - FRAC_W;
  localparam int CNT_W = $clog2(N + 1);
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam logic [K-1:0] LOW_MASK = {K{1'b1}} >> (K - EXTRA);
  localparam logic [EXP_W+FRAC_W:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [EXP_W+FRAC_W:0] PINF =
    {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic                 s_in;
  logic [EXP_W-1:0]     e_in;
  logic [FRAC_W-1:0]    f_in;
  logic                 special, spec_inv, accept, last;
  logic [EXP_W+FRAC_W:0] spec_y;
  logic [FRAC_W+1:0]    rad_init;
  logic [EXP_W-1:0]     exp_init, exp_r, exp_out;
  logic [2*K-1:0]       rad, rad_nx;
  logic [K+1:0]         rem, rem_nx, rem_sh, trial;
  logic [K-1:0]         root, root_nx;
  logic [CNT_W-1:0]     cnt;
  logic [FRAC_W:0]      sig;
  logic [FRAC_W+1:0]    sig_rnd;
  logic [FRAC_W-1:0]    frac_out;
  logic                 guard, sticky, inc;

  assign {s_in, e_in, f_in} = x;
  assign accept = in_valid && in_ready;
  assign last   = (cnt == CNT_W'(1));

  always_comb begin
    special  = 1'b1;
    spec_inv = 1'b0;
    spec_y   = '0;
    if (e_in == '0) begin
      spec_y = {s_in, {(EXP_W+FRAC_W){1'b0}}};
    end else if (e_in == '1 && f_in != '0) begin
      spec_y   = QNAN;
      spec_inv = ~f_in[FRAC_W-1];
    end else if (s_in) begin
      spec_y   = QNAN;
      spec_inv = 1'b1;
    end else if (e_in == '1) begin
      spec_y = PINF;
    end else begin
      special = 1'b0;
    end
  end

  // BIAS is odd, so an odd unbiased exponent means an even E; the radicand is
  // then doubled and (E+BIAS)>>1 gives the halved exponent in both cases.
  assign rad_init = e_in[0] ? {2'b01, f_in} : {1'b1, f_in, 1'b0};
  assign exp_init = (e_in >> 1) + EXP_W'(BIAS >> 1) + EXP_W'(e_in[0]);

  always_comb begin
    rad_nx  = rad;
    rem_nx  = rem;
    root_nx = root;
    rem_sh  = '0;
    trial   = '0;
    for (int unsigned i = 0; i < unsigned'(BPC); i++) begin
      rem_sh = {rem_nx[K-1:0], rad_nx[2*K-1 -: 2]};
      trial  = {root_nx, 2'b01};
      if (rem_sh >= trial) begin
        rem_nx  = rem_sh - trial;
        root_nx = {root_nx[K-2:0], 1'b1};
      end else begin
        rem_nx  = rem_sh;
        root_nx = {root_nx[K-2:0], 1'b0};
      end
      rad_nx = rad_nx << 2;
    end
  end

  always_comb begin
    sig      = root_nx[K-1 -: FRAC_W+1];
    guard    = root_nx[EXTRA];
    sticky   = ((root_nx & LOW_MASK) != '0) || (rem_nx != '0);
    inc      = guard && (sticky || sig[0]);
    sig_rnd  = {1'b0, sig} + (FRAC_W+2)'(inc);
    exp_out  = sig_rnd[FRAC_W+1] ? exp_r + EXP_W'(1) : exp_r;
    frac_out = sig_rnd[FRAC_W+1] ? '0 : sig_rnd[FRAC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = special ? DONE : BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad          <= '0;
      rem          <= '0;
      root         <= '0;
      cnt          <= '0;
      exp_r        <= '0;
      y            <= '0;
      flag_invalid <= 1'b0;
    end else if (accept) begin
      if (special) begin
        y            <= spec_y;
        flag_invalid <= spec_inv;
      end else begin
        rad          <= {rad_init, {SHIFT{1'b0}}};
        rem          <= '0;
        root         <= '0;
        cnt          <= CNT_W'(N);
        exp_r        <= exp_init;
        flag_invalid <= 1'b0;
      end
    end else if (state == BUSY) begin
      rad  <= rad_nx;
      rem  <= rem_nx;
      root <= root_nx;
      cnt  <= cnt - CNT_W'(1);
      if (last) y <= {1'b0, exp_out, frac_out};
    end
  end

endmodule

// File: tb/tb_fsqrt_iter.sv
// Bench for fsqrt_iter: three configurations, directed specials/backpressure/
// reset cases and a random sweep against an exact integer RNE sqrt model.
module tb_fsqrt_iter;

  localparam int BPC1 = 4;
  localparam int EW2  = 11;
  localparam int FW2  = 52;
  localparam int BPC2 = 3;

  logic        clk, rst, in_valid, out_ready;
  logic [63:0] x_t;
  int          sel;
  int          checks, errors;

  logic        iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2, fi0, fi1, fi2;
  logic [31:0] y0, y1;
  logic [63:0] y2;
  logic [63:0] obs_y;
  logic        obs_valid, obs_ready, obs_inv;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  fsqrt_iter u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .x(x_t[31:0]),
    .out_valid(ov0), .out_ready(out_ready), .y(y0), .flag_invalid(fi0)
  );
  fsqrt_iter #(.BPC(BPC1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .x(x_t[31:0]),
    .out_valid(ov1), .out_ready(out_ready), .y(y1), .flag_invalid(fi1)
  );
  fsqrt_iter #(.EXP_W(EW2), .FRAC_W(FW2), .BPC(BPC2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .x(x_t),
    .out_valid(ov2), .out_ready(out_ready), .y(y2), .flag_invalid(fi2)
  );

  always_comb begin
    case (sel)
      1:       begin obs_y = 64'(y1); obs_valid = ov1; obs_ready = ir1; obs_inv = fi1; end
      2:       begin obs_y = y2;      obs_valid = ov2; obs_ready = ir2; obs_inv = fi2; end
      default: begin obs_y = 64'(y0); obs_valid = ov0; obs_ready = ir0; obs_inv = fi0; end
    endcase
  end

  always #5 clk = ~clk;

  function automatic void cfg(input int s, output int ew, output int fw, output int bpc);
    ew = (s == 2) ? EW2 : 8;
    fw = (s == 2) ? FW2 : 23;
    bpc = (s == 0) ? 1 : (s == 1) ? BPC1 : BPC2;
  endfunction

  // Exact reference: binary-searched integer root plus a midpoint test (ties impossible).
  function automatic void ref_sqrt(input logic [63:0] xv, input int ew, input int fw,
                                   output logic [63:0] yv, output logic inv,
                                   output logic spec);
    logic [63:0]  e, f, emax, qnan;
    logic         s;
    logic [127:0] m, r, lo, hi, mid;
    int           u, bias, er;
    emax = (64'd1 << ew) - 1;
    e    = (xv >> fw) & emax;
    f    = xv & ((64'd1 << fw) - 1);
    s    = xv[ew+fw];
    qnan = (emax << fw) | (64'd1 << (fw - 1));
    inv  = 1'b0;
    spec = 1'b1;
    yv   = '0;
    if (e == 0) yv = {63'd0, s} << (ew + fw);
    else if (e == emax && f != 0) begin yv = qnan; inv = ~f[fw-1]; end
    else if (s) begin yv = qnan; inv = 1'b1; end
    else if (e == emax) yv = xv;
    else begin
      spec = 1'b0;
      bias = (1 << (ew - 1)) - 1;
      u = int'(e) - bias;
      m = (128'd1 << fw) | 128'(f);
      if (u % 2 != 0) begin m = m << 1; u = u - 1; end
      m = m << fw;
      lo = 128'd1 << fw;
      hi = 128'd1 << (fw + 1);
      while (hi - lo > 1) begin
        mid = (lo + hi) >> 1;
        if (mid * mid <= m) lo = mid; else hi = mid;
      end
      r = lo;
      if ((m << 2) > ((2 * r + 1) * (2 * r + 1))) r = r + 1;
      er = u / 2 + bias;
      if (r == (128'd1 << (fw + 1))) begin er = er + 1; r = 128'd1 << fw; end
      yv = (64'(er) << fw) | 64'(r - (128'd1 << fw));
    end
  endfunction

  // Drives one operand with out_ready=1 and reports what was observed.
  task automatic do_op(input logic [63:0] xv, output logic [63:0] yv, output logic inv,
                       output int lat, output logic busy_rdy, output logic after_ok);
    x_t = xv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x_t = {$urandom, $urandom};
    lat = 1; busy_rdy = 1'b0;
    while (!obs_valid && lat < 200) begin
      if (obs_ready) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    yv = obs_y; inv = obs_inv;
    if (obs_ready) busy_rdy = 1'b1;
    @(posedge clk); #1;
    after_ok = !obs_valid && obs_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_y !== 64'd0 || obs_inv !== 1'b0) begin
        errors++;
        $display("FAIL reset sel=%0d got valid=%b ready=%b y=%h inv=%b exp 0 1 0 0",
                 s, obs_valid, obs_ready, obs_y, obs_inv);
      end
    end
    sel = 0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] DX [11] = '{32'h40800000, 32'h40000000, 32'h3E800000, 32'h3F800000,
    32'hBF800000, 32'h80000000, 32'h00000001, 32'h7F800000, 32'hFF800000, 32'h7F800001,
    32'h7FC00000};
  localparam logic [31:0] DY [11] = '{32'h40000000, 32'h3FB504F3, 32'h3F000000, 32'h3F800000,
    32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
    32'h7FC00000};
  localparam logic DI [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0};

  task automatic test_directed();
    logic [63:0] yv;
    logic inv, br, ao;
    int lat, el;
    sel = 0; #1;
    for (int i = 0; i < 11; i++) begin
      el = (i < 4) ? 26 : 1;
      do_op(64'(DX[i]), yv, inv, lat, br, ao);
      checks++;
      if (yv !== 64'(DY[i]) || inv !== DI[i]) begin
        errors++;
        $display("FAIL directed x=%h got y=%h inv=%b exp y=%h inv=%b", DX[i], yv, inv, DY[i], DI[i]);
      end
      checks++;
      if (lat !== el) begin
        errors++;
        $display("FAIL directed_latency x=%h got %0d exp %0d", DX[i], lat, el);
      end
      checks++;
      if (br !== 1'b0 || ao !== 1'b1) begin
        errors++;
        $display("FAIL directed_handshake x=%h got busy_ready=%b after_ok=%b exp 0 1", DX[i], br, ao);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] yv;
    logic inv, br, ao;
    int lat, n;
    sel = 0; #1;
    x_t = 64'h40800000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!obs_valid && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (!obs_valid) begin errors++; $display("FAIL bp_wait got valid=0 exp 1"); end
    in_valid = 1'b1; x_t = 64'h40000000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_valid !== 1'b1 || obs_y !== 64'h40000000 || obs_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got valid=%b y=%h ready=%b exp 1 40000000 0",
                 c, obs_valid, obs_y, obs_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got valid=%b ready=%b exp 0 1", obs_valid, obs_ready);
    end
    do_op(64'h3F800000, yv, inv, lat, br, ao);
    checks++;
    if (yv !== 64'h3F800000 || lat !== 26) begin
      errors++;
      $display("FAIL bp_next got y=%h lat=%0d exp 3f800000 26", yv, lat);
    end
  endtask

  task automatic test_reset_busy();
    logic [63:0] yv;
    logic inv, br, ao;
    int lat;
    sel = 0; #1;
    x_t = 64'h40800000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs_valid !== 1'b0 || obs_y !== 64'd0 || obs_ready !== 1'b1 || obs_inv !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got valid=%b y=%h ready=%b inv=%b exp 0 0 1 0",
               obs_valid, obs_y, obs_ready, obs_inv);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_op(64'h40800000, yv, inv, lat, br, ao);
    checks++;
    if (yv !== 64'h40000000 || inv !== 1'b0 || lat !== 26) begin
      errors++;
      $display("FAIL reset_busy_next got y=%h inv=%b lat=%0d exp 40000000 0 26", yv, inv, lat);
    end
  endtask

  task automatic test_random(input int s, input int count);
    int ew, fw, bpc, lat, exp_lat, k;
    logic [63:0] e, f, fmask, xv, yv, ey;
    logic sg, inv, ei, sp, br, ao;
    cfg(s, ew, fw, bpc);
    sel = s; #1;
    fmask = (64'd1 << fw) - 1;
    for (int n = 0; n < count; n++) begin
      sg = 1'b0;
      k = $urandom_range(0, 15);
      e = 64'($urandom_range(1, (1 << ew) - 2));
      f = {$urandom, $urandom} & fmask;
      if (k == 1) e = 64'd1;
      else if (k == 2) e = 64'((1 << ew) - 2);
      else if (k == 3) f = fmask;
      else if (k == 0) begin
        case ($urandom_range(0, 3))
          0: begin e = 0; sg = 1'($urandom); end
          1: begin e = 64'((1 << ew) - 1); sg = 1'($urandom); if ($urandom_range(0, 1) == 0) f = 0; end
          2: sg = 1'b1;
          default: begin e = 64'((1 << ew) - 1); f = 0; end
        endcase
      end
      xv = ({63'd0, sg} << (ew + fw)) | (e << fw) | f;
      ref_sqrt(xv, ew, fw, ey, ei, sp);
      exp_lat = sp ? 1 : (fw + 2 + bpc - 1) / bpc + 1;
      do_op(xv, yv, inv, lat, br, ao);
      checks++;
      if (yv !== ey || inv !== ei) begin
        errors++;
        $display("FAIL rand_result sel=%0d x=%h got y=%h inv=%b exp y=%h inv=%b", s, xv, yv, inv, ey, ei);
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL rand_latency sel=%0d x=%h got %0d exp %0d", s, xv, lat, exp_lat);
      end
      checks++;
      if (br !== 1'b0 || ao !== 1'b1) begin
        errors++;
        $display("FAIL rand_handshake sel=%0d x=%h got busy_ready=%b after_ok=%b exp 0 1", s, xv, br, ao);
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_t = '0; sel = 0;
    checks = 0; errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_busy();
    test_random(0, 300);
    test_random(1, 400);
    test_random(2, 300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
